// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and word geometry.
// No logic; no latency; no flow control.
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs little-endian bytes into 32-bit words; word_ready flags the byte that completes a word.
// Latency: word_out is combinational on the completing byte. Backpressure: caller gates accept.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word_out
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      shift_q;

  // Newest byte enters at the top, so after four shifts byte 0 sits in [7:0].
  assign word_out   = {byte_in, shift_q[31:8]};
  assign word_ready = accept && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 1'b1;
      shift_q  <= word_out;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams program bytes into instruction memory one 32-bit word at a time; INSTR_LOADER_CHECKSUM_EN adds an XOR checksum.
// Latency: write strobe the cycle after a word's 4th byte; done_out two cycles after the last write.
// Backpressure: byte_ready_out is high only while assembling; bytes offered at other times are not consumed.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH_POW = 6,
  parameter int ADDR_WIDTH     = 1 << ADDR_WIDTH_POW,
  parameter int MEM_DEPTH_POW  = 10,
  parameter int MEM_DEPTH      = 1 << MEM_DEPTH_POW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic [MEM_DEPTH_POW:0] num_words_in,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid_in,
  output logic                   byte_ready_out,
  output logic                   wr_en_out,
  output logic [ADDR_WIDTH-1:0]  wr_addr_out,
  output logic [31:0]            wr_data_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   error_out,
  output logic [31:0]            checksum_out
);

  localparam int               IDX_W       = MEM_DEPTH_POW + 1;
  localparam logic [IDX_W-1:0] DEPTH_LIMIT = IDX_W'(MEM_DEPTH);

  loader_state_t    state;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] word_cnt;
  logic [IDX_W-1:0] word_idx_nxt;
  logic             accept;
  logic             load_start;
  logic             word_ready;
  logic [31:0]      packed_word;

  assign accept       = byte_valid_in & byte_ready_out;
  assign load_start   = (state == ST_IDLE) && start_in &&
                        (num_words_in != '0) && (num_words_in <= DEPTH_LIMIT);
  assign word_idx_nxt = word_idx + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (load_start),
    .accept     (accept),
    .byte_in    (byte_in),
    .word_ready (word_ready),
    .word_out   (packed_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      word_idx       <= '0;
      word_cnt       <= '0;
      byte_ready_out <= 1'b0;
      wr_en_out      <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      error_out      <= 1'b0;
    end else begin
      wr_en_out <= 1'b0;
      done_out  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            if (num_words_in > DEPTH_LIMIT) begin
              error_out <= 1'b1;
            end else if (num_words_in == '0) begin
              state <= ST_DONE;
            end else begin
              word_cnt       <= num_words_in;
              word_idx       <= '0;
              error_out      <= 1'b0;
              byte_ready_out <= 1'b1;
              busy_out       <= 1'b1;
              state          <= ST_ASSEMBLE;
            end
          end
        end
        ST_ASSEMBLE: begin
          // Outputs are loaded on the completing byte so the strobe lines up with WRITE.
          if (word_ready) begin
            byte_ready_out <= 1'b0;
            wr_en_out      <= 1'b1;
            wr_addr_out    <= ADDR_WIDTH'({word_idx, 2'b00});
            wr_data_out    <= packed_word;
            state          <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          word_idx <= word_idx_nxt;
          if (word_idx_nxt == word_cnt) begin
            busy_out <= 1'b0;
            state    <= ST_DONE;
          end else begin
            byte_ready_out <= 1'b1;
            state          <= ST_ASSEMBLE;
          end
        end
        ST_DONE: begin
          done_out <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_out <= '0;
    end else if (load_start) begin
      checksum_out <= '0;
    end else if (state == ST_WRITE) begin
      checksum_out <= checksum_out ^ wr_data_out;
    end
  end
`else
  assign checksum_out = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of loads plus hand-written reset/ignore sequences.
// Expected writes are queued as bytes are driven and popped when wr_en_out fires.
module tb_instr_mem_loader;

  localparam int ADDR_WIDTH    = 64;
  localparam int MEM_DEPTH_POW = 10;
  localparam int MEM_DEPTH     = 1 << MEM_DEPTH_POW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_in;
  logic [MEM_DEPTH_POW:0] num_words_in;
  logic [7:0]             byte_in;
  logic                   byte_valid_in;
  logic                   byte_ready_out;
  logic                   wr_en_out;
  logic [ADDR_WIDTH-1:0]  wr_addr_out;
  logic [31:0]            wr_data_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   error_out;
  logic [31:0]            checksum_out;

  instr_mem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start_in       (start_in),
    .num_words_in   (num_words_in),
    .byte_in        (byte_in),
    .byte_valid_in  (byte_valid_in),
    .byte_ready_out (byte_ready_out),
    .wr_en_out      (wr_en_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out),
    .checksum_out   (checksum_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  int n_done   = 0;

  logic [ADDR_WIDTH-1:0] q_addr[$];
  logic [31:0]           q_data[$];

  typedef struct {
    int          num;
    bit          gap;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_error;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en_out === 1'b1) begin
      n_writes++;
      if (q_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", wr_addr_out, wr_data_out);
      end else begin
        check("write_addr", 64'(wr_addr_out), 64'(q_addr.pop_front()));
        check("write_data", 64'(wr_data_out), 64'(q_data.pop_front()));
      end
    end
    if (done_out === 1'b1) n_done++;
  end

  function automatic logic [31:0] gen_word(input int i);
    return (32'(i) + 32'd1) * 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] exp_checksum(input logic [31:0] x);
`ifdef INSTR_LOADER_CHECKSUM_EN
    return x;
`else
    return (x & 32'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard = 0;
    if (gap) begin
      byte_valid_in = 1'b0;
      tick();
    end
    byte_valid_in = 1'b1;
    byte_in       = b;
    while (byte_ready_out !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    tick();
    byte_valid_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start(input int num);
    start_in     = 1'b1;
    num_words_in = (MEM_DEPTH_POW + 1)'(num);
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int guard = 0;
    while (done_out !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check({name, "_done_seen"}, 64'(done_out), 64'd1);
    tick();
    check({name, "_done_one_cycle"}, 64'(done_out), 64'd0);
  endtask

  task automatic run_load(input vec_t v);
    int          w0_cnt = n_writes;
    int          d0_cnt = n_done;
    logic [31:0] x = '0;
    logic [31:0] w;
    pulse_start(v.num);
    if (v.exp_error) begin
      check("reject_error", 64'(error_out), 64'd1);
      repeat (4) tick();
      check("reject_no_write", 64'(n_writes - w0_cnt), 64'd0);
      check("reject_idle_ready", 64'({busy_out, byte_ready_out}), 64'd0);
    end else if (v.num == 0) begin
      check("zero_done_early", 64'(done_out), 64'd0);
      tick();
      check("zero_done_pulse", 64'(done_out), 64'd1);
      tick();
      check("zero_done_clear", 64'(done_out), 64'd0);
      check("zero_no_write", 64'(n_writes - w0_cnt), 64'd0);
    end else begin
      check("start_error_clear", 64'(error_out), 64'd0);
      check("start_busy", 64'(busy_out), 64'd1);
      for (int i = 0; i < v.num; i++) begin
        w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : gen_word(i);
        q_addr.push_back(ADDR_WIDTH'(i * 4));
        q_data.push_back(w);
        x ^= w;
        send_word(w, v.gap);
      end
      wait_done("load");
      check("load_write_count", 64'(n_writes - w0_cnt), 64'(v.num));
      check("load_done_count", 64'(n_done - d0_cnt), 64'd1);
      check("load_queue_empty", 64'(q_addr.size()), 64'd0);
      check("load_addr_hold", 64'(wr_addr_out), 64'((v.num - 1) * 4));
      check("load_checksum", 64'(checksum_out), 64'(exp_checksum(x)));
      check("load_idle", 64'({busy_out, byte_ready_out, wr_en_out}), 64'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int w0_cnt;
    vecs[0] = '{num: 2,             gap: 1'b0, w0: 32'h0000_0013, w1: 32'h0010_0093, exp_error: 1'b0};
    vecs[1] = '{num: 1,             gap: 1'b1, w0: 32'hDEAD_BEEF, w1: 32'h0,          exp_error: 1'b0};
    vecs[2] = '{num: MEM_DEPTH + 1, gap: 1'b0, w0: 32'h0,         w1: 32'h0,          exp_error: 1'b1};
    vecs[3] = '{num: 3,             gap: 1'b0, w0: 32'h1122_3344, w1: 32'h5566_7788, exp_error: 1'b0};
    vecs[4] = '{num: 0,             gap: 1'b0, w0: 32'h0,         w1: 32'h0,          exp_error: 1'b0};
    vecs[5] = '{num: 5,             gap: 1'b1, w0: 32'hA5A5_5A5A, w1: 32'h0F0F_F0F0, exp_error: 1'b0};
    vecs[6] = '{num: MEM_DEPTH,     gap: 1'b0, w0: 32'h0123_4567, w1: 32'h89AB_CDEF, exp_error: 1'b0};

    rst           = 1'b1;
    start_in      = 1'b0;
    num_words_in  = '0;
    byte_in       = '0;
    byte_valid_in = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({byte_ready_out, wr_en_out, busy_out, done_out, error_out}), 64'd0);
    check("reset_addr", 64'(wr_addr_out), 64'd0);
    check("reset_data", 64'(wr_data_out), 64'd0);
    check("reset_checksum", 64'(checksum_out), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i]);
      tick();
    end

    // Bytes offered in IDLE and a start pulse mid-load must both be ignored.
    byte_valid_in = 1'b1;
    byte_in       = 8'hFF;
    repeat (3) tick();
    check("idle_no_ready", 64'(byte_ready_out), 64'd0);
    byte_valid_in = 1'b0;
    w0_cnt = n_writes;
    pulse_start(1);
    q_addr.push_back('0);
    q_data.push_back(32'h0BAD_F00D);
    send_byte(8'h0D, 1'b0);
    pulse_start(0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'h0B, 1'b0);
    wait_done("ignore");
    check("ignore_write_count", 64'(n_writes - w0_cnt), 64'd1);
    repeat (3) tick();
    check("ignore_no_extra_done", 64'(done_out), 64'd0);

    // Reset midway through the second word abandons it; the next load restarts at address 0.
    pulse_start(2);
    q_addr.push_back('0);
    q_data.push_back(32'h7654_3210);
    send_word(32'h7654_3210, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDD, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_outputs", 64'({byte_ready_out, wr_en_out, busy_out, done_out, error_out}), 64'd0);
    check("midrst_addr_data", 64'({wr_addr_out[31:0], wr_data_out}), 64'd0);
    rst = 1'b0;
    q_addr.delete();
    q_data.delete();
    tick();
    run_load('{num: 1, gap: 1'b0, w0: 32'hCAFE_BABE, w1: 32'h0, exp_error: 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH_POW, default 6, log2 of address width.
REQ-002 Parameter ADDR_WIDTH, default 1 << ADDR_WIDTH_POW, byte-address width.
REQ-003 Parameter MEM_DEPTH_POW, default 10, log2 of instruction-memory depth in words.
REQ-004 Parameter MEM_DEPTH, default 1 << MEM_DEPTH_POW, words in instruction memory.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 start_in  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-008 num_words_in  input  MEM_DEPTH_POW+1  word count to load; sampled on accepted start_in.
REQ-009 byte_in  input  8  incoming program byte, little-endian order.
REQ-010 byte_valid_in  input  1  byte_in holds a valid byte.
REQ-011 byte_ready_out  output  1  loader accepts a byte this cycle.
REQ-012 wr_en_out  output  1  instruction-memory write strobe.
REQ-013 wr_addr_out  output  ADDR_WIDTH  byte address of the word written, always a multiple of 4.
REQ-014 wr_data_out  output  32  assembled instruction word.
REQ-015 busy_out  output  1  high in ASSEMBLE and WRITE.
REQ-016 done_out  output  1  one-cycle pulse on load completion.
REQ-017 error_out  output  1  sticky; indicates the requested count was rejected.
REQ-018 checksum_out  output  32  XOR of all words written in the current load.

Function
REQ-019 The FSM SHALL have states IDLE, ASSEMBLE, WRITE and DONE.
REQ-020 IDLE + start_in: if num_words_in > MEM_DEPTH, set error_out and stay in IDLE; if it is 0, go to DONE; otherwise latch the count, clear word index, byte index, error_out and checksum, and go to ASSEMBLE.
REQ-021 byte_ready_out SHALL equal 1 only in ASSEMBLE; a byte transfers when byte_valid_in and byte_ready_out are both high on a rising edge.
REQ-022 Byte k (0..3) of a word SHALL be placed at wr_data_out[8k+7:8k]; after the 4th accepted byte the FSM goes to WRITE.
REQ-023 In WRITE, for exactly one cycle: wr_en_out=1, wr_addr_out=word_index*4, wr_data_out=assembled word.
REQ-024 After WRITE, the word index SHALL increment; if it equals the latched count, go to DONE, else go to ASSEMBLE with byte index 0.
REQ-025 DONE SHALL assert done_out for one cycle and then return to IDLE.
REQ-026 start_in outside IDLE SHALL be ignored; byte_valid_in outside ASSEMBLE SHALL be ignored (no byte consumed).
REQ-027 Gaps in byte_valid_in SHALL stall assembly without losing partial-word state.
REQ-028 wr_en_out SHALL be 0 in all states other than WRITE; wr_addr_out and wr_data_out hold their last values otherwise.
REQ-029 Word-index width SHALL be MEM_DEPTH_POW+1; a load of MEM_DEPTH words SHALL reach the final address (MEM_DEPTH-1)*4 without wrap.

Reset
REQ-030 rst SHALL asynchronously force IDLE and zero all outputs, indices, and the assembly register, including mid-load; partially loaded words are abandoned.

Configuration
REQ-031 With INSTR_LOADER_CHECKSUM_EN defined, checksum_out SHALL be XOR-accumulated with wr_data_out on each WRITE cycle and held until the next accepted start_in.
REQ-032 Without INSTR_LOADER_CHECKSUM_EN, checksum_out SHALL be tied to 0 and no accumulator logic synthesised.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum loader_state_t and the BYTES_PER_WORD=4 constant.
REQ-034 Byte-to-word packing SHALL live in sub-module byte_packer (byte index, shift register, word_ready flag).

Verification
REQ-035 Reset -> all outputs 0, FSM in IDLE, byte_ready_out=0.
REQ-036 start, num_words=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0, 0x00100093 @0x4, then done_out pulses once; checksum 0x00100080 when the macro is defined.
REQ-037 num_words=1, bytes delivered with byte_valid_in toggling every other cycle -> single write of the correct word, no lost or duplicated byte.
REQ-038 num_words=MEM_DEPTH+1 -> error_out=1, no wr_en_out, still IDLE; a following valid start clears error_out.
REQ-039 num_words=0 -> done_out pulses 2 cycles after start, no write.
REQ-040 rst asserted after 2 bytes of word 1 -> immediate IDLE; a new load writes its first word at address 0 with no stale bytes.
